bcd_adder_scan_display: RTL and testbench

BCD_ADDER_SCAN_DISPLAY -- requirements
Module: bcd_adder_scan_display

---
 rtl/bcd7_pkg.sv | 27 ++
 rtl/bcd_adder_scan_display_if.sv | 32 +++
 rtl/bcd_to_7seg.sv | 38 +++
 rtl/bcd_adder_scan_display.sv | 175 +++++++++++++++++
 tb/tb_bcd_adder_scan_display.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd7_pkg.sv
// Shared definitions for the BCD adder / scanned 7-segment display block.
//   state_e      : adder FSM state encoding (IDLE, ADD, DONE)
//   SEG_0..SEG_9 : active-low digit patterns, bit [0]=a ... bit [6]=g
//   SEG_BLANK    : every segment off
//   SEG_DASH     : only segment g lit
package bcd7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_adder_scan_display_if.sv
// Signal bundle for one bcd_adder_scan_display instance.
//   master : the requester side (drives start, a, b; observes the rest)
//   slave  : the adder/display side
// Handshake: start is a request sampled on a rising clk edge only while
// busy=0; a and b are captured on that same edge. busy stays high from the
// following cycle until the result is written, and done pulses for exactly
// one cycle once the new result is on the display. start while busy=1 is
// dropped, not queued.
interface bcd_adder_scan_display_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                busy;
    logic                done;
    logic                err;
    logic [NDIG:0]       an;
    logic [6:0]          segment;
    logic                dp;
    logic [3:0]          led;

    modport master (
        output start, a, b,
        input  busy, done, err, an, segment, dp, led
    );

    modport slave (
        input  start, a, b,
        output busy, done, err, an, segment, dp, led
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
//   digit : 4-bit BCD value
//   blank : force all segments off
//   dash  : force a dash (only g lit); takes priority over blank
//   seg   : active-low segments, [0]=a ... [6]=g
module bcd_to_7seg
    import bcd7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                // A non-BCD code can only reach here from a bad add, which
                // already forces dashes; show a dash anyway to be safe.
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_adder_scan_display.sv
// Digit-serial BCD adder feeding a multiplexed 7-segment display.
//   clk, rst     : single clock, synchronous active-high reset
//   start, a, b  : add request and NDIG-digit BCD operands
//   busy, done   : adder status (busy in ADD/DONE, done one-cycle pulse)
//   err          : last operands held a non-BCD digit
//   an           : active-low one-hot digit enable (NDIG+1 digits)
//   segment, dp  : active-low segments and decimal point
//   led          : BCD value of the digit currently scanned
module bcd_adder_scan_display
    import bcd7_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZB         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [NDIG:0]     an,
    output logic [6:0]        segment,
    output logic              dp,
    output logic [3:0]        led
);

    localparam int IDX_W = $clog2(NDIG + 1);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int RW    = 4 * (NDIG + 1);

    state_e            state_q, state_d;
    logic [4*NDIG-1:0] a_q, a_d, b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RW-1:0]     res_q, res_d;
    logic [RW-1:0]     disp_q, disp_d;
    logic              err_flag_q, err_flag_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  scan_q, scan_d;

    logic [3:0]        dig_a, dig_b, cur_digit;
    logic [4:0]        sum;
    logic [NDIG:0]     zero_from;
    logic              blank_cur;

    assign dig_a = a_q[4*idx_q +: 4];
    assign dig_b = b_q[4*idx_q +: 4];

    // Adder FSM: one digit per ADD cycle, then a single DONE cycle that
    // publishes the result to the display register.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        res_d      = res_q;
        disp_d     = disp_q;
        err_flag_d = err_flag_q;
        err_d      = err_q;
        done_d     = 1'b0;
        sum        = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry_q};
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = 1'b0;
                    idx_d      = '0;
                    res_d      = '0;
                    err_flag_d = 1'b0;
                    state_d    = ADD;
                end
            end
            ADD: begin
                if (dig_a > 4'd9 || dig_b > 4'd9) begin
                    err_flag_d = 1'b1;
                end
                // Decimal adjust: adding 6 skips the six unused codes.
                if (sum > 5'd9) begin
                    res_d[4*idx_q +: 4] = 4'(sum + 5'd6);
                    carry_d             = 1'b1;
                end else begin
                    res_d[4*idx_q +: 4] = sum[3:0];
                    carry_d             = 1'b0;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NDIG - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_d[RW-1 -: 4] = {3'b0, carry_q};
                disp_d           = {3'b0, carry_q, res_q[4*NDIG-1:0]};
                err_d            = err_flag_q;
                done_d           = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running refresh divider and scan index.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        scan_d = scan_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d  = '0;
            scan_d = (scan_q == IDX_W'(NDIG)) ? '0 : scan_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            res_q      <= '0;
            disp_q     <= '0;
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            scan_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            disp_q     <= disp_d;
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
        end
    end

    // zero_from[i] is set when digit i and every digit above it are zero,
    // which is exactly the leading-zero condition for digit i.
    always_comb begin
        zero_from       = '0;
        zero_from[NDIG] = (disp_q[4*NDIG +: 4] == 4'd0);
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_from[i] = (disp_q[4*i +: 4] == 4'd0) && zero_from[i+1];
        end
    end

    assign cur_digit = disp_q[4*scan_q +: 4];
    assign blank_cur = (LZB != 0) && (scan_q != '0) && zero_from[scan_q];

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;
    assign an   = ~((NDIG + 1)'(1) << scan_q);
    assign dp   = ~err_q;
    assign led  = (err_q || blank_cur) ? 4'd0 : cur_digit;

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .blank (blank_cur),
        .dash  (err_q),
        .seg   (segment)
    );

endmodule

// File: tb/tb_bcd_adder_scan_display.sv
module tb_bcd_adder_scan_display;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bcd_adder_scan_display_if #(.NDIG(4)) bus ();

    bcd_adder_scan_display #(
        .NDIG        (4),
        .REFRESH_DIV (4),
        .LZB         (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (bus.busy),
        .done    (bus.done),
        .err     (bus.err),
        .an      (bus.an),
        .segment (bus.segment),
        .dp      (bus.dp),
        .led     (bus.led)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one add and measure cycles from start to the done pulse.
    task automatic do_add(input string tag, input logic [15:0] av, input logic [15:0] bv);
        int lat;
        bit seen;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            bus.start = 1'b0;
            if (lat == 1) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd6);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    // Wait for the scan to freshly enter digit idx.
    task automatic wait_scan(input int idx);
        logic [4:0] tgt, prev;
        bit found;
        tgt   = ~(5'b00001 << idx);
        prev  = bus.an;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            if (bus.an == tgt && prev != tgt) found = 1'b1;
            prev = bus.an;
        end
        chk($sformatf("scan_reach_%0d", idx), 32'(found), 32'd1);
    endtask

    task automatic chk_digit(input string tag, input int idx, input logic [6:0] seg,
                             input logic [3:0] ledv, input logic dpv);
        wait_scan(idx);
        chk($sformatf("%s_d%0d_seg", tag, idx), 32'(bus.segment), 32'(seg));
        chk($sformatf("%s_d%0d_led", tag, idx), 32'(bus.led), 32'(ledv));
        chk($sformatf("%s_d%0d_dp", tag, idx), 32'(bus.dp), 32'(dpv));
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_an", 32'(bus.an), 32'h1E);
        chk("rst_seg", 32'(bus.segment), 32'h40);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_led", 32'(bus.led), 32'd0);
        rst = 1'b0;
        tick();

        // 1234 + 5678 = 06912, top zero blanked
        do_add("add1", 16'h1234, 16'h5678);
        chk("add1_err", 32'(bus.err), 32'd0);
        chk_digit("add1", 0, 7'h24, 4'd2, 1'b1);
        chk_digit("add1", 1, 7'h79, 4'd1, 1'b1);
        chk_digit("add1", 2, 7'h10, 4'd9, 1'b1);
        chk_digit("add1", 3, 7'h02, 4'd6, 1'b1);
        chk_digit("add1", 4, 7'h7F, 4'd0, 1'b1);

        // 9999 + 0001 = 10000, all digits lit
        do_add("add2", 16'h9999, 16'h0001);
        chk_digit("add2", 0, 7'h40, 4'd0, 1'b1);
        chk_digit("add2", 1, 7'h40, 4'd0, 1'b1);
        chk_digit("add2", 2, 7'h40, 4'd0, 1'b1);
        chk_digit("add2", 3, 7'h40, 4'd0, 1'b1);
        chk_digit("add2", 4, 7'h79, 4'd1, 1'b1);

        // Non-BCD operand digit: dashes everywhere
        do_add("add3", 16'h12A4, 16'h0001);
        chk("add3_err", 32'(bus.err), 32'd1);
        chk_digit("add3", 0, 7'h3F, 4'd0, 1'b0);
        chk_digit("add3", 2, 7'h3F, 4'd0, 1'b0);
        chk_digit("add3", 4, 7'h3F, 4'd0, 1'b0);

        // A valid add clears err
        do_add("add4", 16'h0001, 16'h0001);
        chk("add4_err", 32'(bus.err), 32'd0);
        chk_digit("add4", 0, 7'h24, 4'd2, 1'b1);

        // start every cycle for 10 cycles: only captures at cycles 0 and 6
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        bus.b       = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            bus.start = (c < 10);
            bus.a     = (c < 10) ? 16'(c) : 16'h0000;
            tick();
            if (bus.done) begin
                done_cnt++;
                if (first_done < 0) first_done = c + 1;
                else if (second_done < 0) second_done = c + 1;
            end
        end
        bus.start = 1'b0;
        chk("burst_done_count", 32'(done_cnt), 32'd2);
        chk("burst_first_done", 32'(first_done), 32'd6);
        chk("burst_second_done", 32'(second_done), 32'd12);
        chk_digit("burst", 0, 7'h02, 4'd6, 1'b1);

        // Reset two cycles into ADD aborts the add
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_an", 32'(bus.an), 32'h1E);
        chk("abort_seg", 32'(bus.segment), 32'h40);
        chk("abort_led", 32'(bus.led), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_busy_after", 32'(bus.busy), 32'd0);

        // 0003 + 0004: scan steps every 4 cycles, only digit 0 lit
        do_add("add5", 16'h0003, 16'h0004);
        wait_scan(0);
        chk("add5_an0", 32'(bus.an), 32'h1E);
        chk("add5_seg0", 32'(bus.segment), 32'h78);
        chk("add5_led0", 32'(bus.led), 32'd7);
        for (int k = 1; k <= 4; k++) begin
            repeat (4) tick();
            chk($sformatf("add5_an%0d", k), 32'(bus.an), 32'(5'(~(5'b00001 << k))));
            chk($sformatf("add5_seg%0d", k), 32'(bus.segment), 32'h7F);
            chk($sformatf("add5_led%0d", k), 32'(bus.led), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
